i2s_mic_rx: RTL

I2S master receiver for a MEMS microphone (INMP441-class, 24-bit, 64 SCK per frame). It generates SCK and WS and deserialises the selected channel. Each sample is scaled by a runtime gain with saturation to 16-bit signed. Output is the data/data_we sample stream consumed by the oscilloscope capture stage, which triggers on data ≥ threshold and displays data[15] and data[7:0].

---
 rtl/i2s_mic_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a 24-bit MEMS microphone (64 SCK per frame).
// Generates SCK/WS, deserialises the selected slot, applies a runtime gain
// with 16-bit signed saturation and emits one sample strobe per frame.
//
// Output handshake: data/sat are valid in the single cycle data_we is high.
// There is no ready input; the consumer must take every strobe. data holds
// its last value between strobes.
module i2s_mic_rx #(
    parameter int CLK_DIV        = 8,
    parameter int STARTUP_FRAMES = 4096
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        i2s_sd,
    input  logic        chan_sel,
    input  logic [2:0]  gain,
    output logic        i2s_sck,
    output logic        i2s_ws,
    output logic [15:0] data,
    output logic        data_we,
    output logic        sat,
    output logic        running
);

    typedef enum logic {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [12:0] LAST_FRAME = (STARTUP_FRAMES > 0) ? 13'(STARTUP_FRAMES - 1) : 13'd0;
    localparam logic signed [23:0] S16_MAX = 24'sd32767;
    localparam logic signed [23:0] S16_MIN = -24'sd32768;

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        sck_q, sck_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        sd_r_q, sd_r_d;
    logic [23:0] sr_q, sr_d;
    logic        chan_q, chan_d;
    logic [2:0]  gain_q, gain_d;
    logic        pend_q, pend_d;
    logic [12:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        sat_q, sat_d;

    logic        tick;
    logic        sck_rise;
    logic        sck_fall;
    logic        wrap;
    logic [4:0]  slot;
    logic        cap;
    logic [3:0]  shamt;
    logic signed [23:0] scaled;
    logic [15:0] sample;
    logic        clip;

    // Clock divider, bit counter, per-frame latches and the capture shifter
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        sck_rise  = tick && !sck_q;
        sck_fall  = tick && sck_q;
        wrap      = sck_fall && (bit_cnt_q == 6'd63);
        slot      = bit_cnt_q[4:0];
        cap       = sck_rise && (slot >= 5'd1) && (slot <= 5'd24) && (bit_cnt_q[5] == chan_q);

        div_cnt_d = div_cnt_q + 8'd1;
        sck_d     = sck_q;
        bit_cnt_d = bit_cnt_q;
        sd_r_d    = i2s_sd;
        sr_d      = sr_q;
        chan_d    = chan_q;
        gain_d    = gain_q;
        pend_d    = cap && (slot == 5'd24);

        if (tick) begin
            div_cnt_d = 8'd0;
            sck_d     = ~sck_q;
        end
        if (sck_fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
        end
        if (wrap) begin
            chan_d = chan_sel;
            gain_d = gain;
        end
        if (cap) begin
            sr_d = {sr_q[22:0], sd_r_q};
        end
    end

    // Gain scaling: arithmetic right shift by (8 - gain), then clamp to 16 bits
    always_comb begin
        shamt  = 4'd8 - {1'b0, gain_q};
        scaled = $signed(sr_q) >>> shamt;
        sample = scaled[15:0];
        clip   = 1'b0;
        if (scaled > S16_MAX) begin
            sample = 16'h7FFF;
            clip   = 1'b1;
        end else if (scaled < S16_MIN) begin
            sample = 16'h8000;
            clip   = 1'b1;
        end
    end

    // Startup/run FSM: suppress strobes until the microphone has woken up
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        data_d      = data_q;
        we_d        = 1'b0;
        sat_d       = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (wrap) begin
                    frame_cnt_d = frame_cnt_q + 13'd1;
                end
                if (STARTUP_FRAMES == 0) begin
                    state_d = ST_RUN;
                end else if (wrap && (frame_cnt_q == LAST_FRAME)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pend_q) begin
                    we_d   = 1'b1;
                    sat_d  = clip;
                    data_d = sample;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    // All state registers; a reset anywhere in a word discards it
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= ST_STARTUP;
            div_cnt_q   <= 8'd0;
            sck_q       <= 1'b0;
            bit_cnt_q   <= 6'd0;
            sd_r_q      <= 1'b0;
            sr_q        <= 24'd0;
            chan_q      <= 1'b0;
            gain_q      <= 3'd0;
            pend_q      <= 1'b0;
            frame_cnt_q <= 13'd0;
            data_q      <= 16'd0;
            we_q        <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sck_q       <= sck_d;
            bit_cnt_q   <= bit_cnt_d;
            sd_r_q      <= sd_r_d;
            sr_q        <= sr_d;
            chan_q      <= chan_d;
            gain_q      <= gain_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            we_q        <= we_d;
            sat_q       <= sat_d;
        end
    end

    assign i2s_sck = sck_q;
    assign i2s_ws  = bit_cnt_q[5];
    assign data    = data_q;
    assign data_we = we_q;
    assign sat     = sat_q;
    assign running = (state_q == ST_RUN);

endmodule
